// File: rtl/dsp_post_adder_pkg.sv
// Shared constants for the DSP48A1-style post-adder: operand mux codes,
// opmode bit positions and datapath widths.
package dsp_pkg;

    localparam int P_W = 48;
    localparam int M_W = 36;

    localparam int SUB_BIT = 7;
    localparam int X_LSB   = 0;
    localparam int Z_LSB   = 2;

    // The opmode register keeps only the bits this stage uses: {sub, z, x}.
    localparam int OP_REG_W = 5;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

endpackage

// File: rtl/dsp_post_adder_pipe_reg_async.sv
// Clock-enabled pipeline register with asynchronous reset and an optional
// combinational bypass; the flop is always present even when bypassed.
module pipe_reg_async #(
    parameter int WIDTH = 1,
    parameter bit REG   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = ce ? d : data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = REG ? data_q : d;

endmodule

// File: rtl/dsp_post_adder.sv
// Post-adder/accumulator stage of a DSP48A1 slice: X/Z operand selection,
// add or subtract with carry-in, and the P / CARRYOUT output registers.
module dsp_post_adder
    import dsp_pkg::*;
#(
    parameter bit PREG        = 1'b1,
    parameter bit CARRYOUTREG = 1'b1,
    parameter bit CARRYINREG  = 1'b1,
    parameter bit OPMODEREG   = 1'b1,
    parameter int WIDTH       = P_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cep,
    input  logic             cecarryin,
    input  logic             ceopmode,
    input  logic [7:0]       opmode,
    input  logic [M_W-1:0]   m_in,
    input  logic [WIDTH-1:0] dab_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] pcin,
    input  logic             carry_in,
    output logic [WIDTH-1:0] p,
    output logic [WIDTH-1:0] pcout,
    output logic             carryout,
    output logic             carryoutf
);

    logic [OP_REG_W-1:0] op_in;
    logic [OP_REG_W-1:0] op_reg_out;
    logic [OP_REG_W-1:0] op_eff;
    logic                cin_reg_out;
    logic                cin_eff;
    logic [1:0]          x_sel;
    logic [1:0]          z_sel;
    logic                sub_eff;
    logic [WIDTH-1:0]    x_op;
    logic [WIDTH-1:0]    z_op;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    p_fb;
    logic                unused_opmode;

    assign op_in         = {opmode[SUB_BIT], opmode[Z_LSB+1:Z_LSB], opmode[X_LSB+1:X_LSB]};
    assign unused_opmode = ^opmode[6:4];

    pipe_reg_async #(.WIDTH(OP_REG_W), .REG(OPMODEREG)) u_opmode_reg (
        .clk (clk),
        .rst (rst),
        .ce  (ceopmode),
        .d   (op_in),
        .q   (op_reg_out)
    );

    pipe_reg_async #(.WIDTH(1), .REG(CARRYINREG)) u_carryin_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cecarryin),
        .d   (carry_in),
        .q   (cin_reg_out)
    );

    // Control arrives aligned with its data, so an enabled control register
    // takes effect in the same cycle; with CE low the held value is used.
    always_comb begin
        op_eff  = ceopmode ? op_in : op_reg_out;
        cin_eff = cecarryin ? carry_in : cin_reg_out;
        x_sel   = op_eff[1:0];
        z_sel   = op_eff[3:2];
        sub_eff = op_eff[4];
    end

    always_comb begin
        x_op = '0;
        case (x_sel)
            X_ZERO:  x_op = '0;
            X_M:     x_op = {{(WIDTH-M_W){1'b0}}, m_in};
            X_P:     x_op = p_fb;
            X_DAB:   x_op = dab_in;
            default: x_op = '0;
        endcase

        z_op = '0;
        case (z_sel)
            Z_ZERO:  z_op = '0;
            Z_PCIN:  z_op = pcin;
            Z_P:     z_op = p_fb;
            Z_C:     z_op = c_in;
            default: z_op = '0;
        endcase

        if (sub_eff) begin
            sum = {1'b0, z_op} - ({1'b0, x_op} + {{WIDTH{1'b0}}, cin_eff});
        end else begin
            sum = {1'b0, z_op} + {1'b0, x_op} + {{WIDTH{1'b0}}, cin_eff};
        end
    end

    // The P flop is always used as the feedback tap, so PREG only chooses
    // what drives the output; this keeps PREG=0 free of combinational loops.
    pipe_reg_async #(.WIDTH(WIDTH), .REG(1'b1)) u_p_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cep),
        .d   (sum[WIDTH-1:0]),
        .q   (p_fb)
    );

    pipe_reg_async #(.WIDTH(1), .REG(CARRYOUTREG)) u_carryout_reg (
        .clk (clk),
        .rst (rst),
        .ce  (cep),
        .d   (sum[WIDTH]),
        .q   (carryout)
    );

    assign p         = PREG ? p_fb : sum[WIDTH-1:0];
    assign pcout     = p;
    assign carryoutf = carryout;

endmodule

// File: tb/tb_dsp_post_adder.sv
// Self-checking bench for dsp_post_adder: directed scenarios plus a randomized
// run compared against a behavioural model of the post-adder.
module tb_dsp_post_adder;

    logic        clk;
    logic        rst;
    logic        cep;
    logic        cecarryin;
    logic        ceopmode;
    logic [7:0]  opmode;
    logic [35:0] m_in;
    logic [47:0] dab_in;
    logic [47:0] c_in;
    logic [47:0] pcin;
    logic        carry_in;

    logic [47:0] p;
    logic [47:0] pcout;
    logic        carryout;
    logic        carryoutf;

    logic [47:0] p_b;
    logic [47:0] pcout_b;
    logic        carryout_b;
    logic        carryoutf_b;

    int checks;
    int errors;

    dsp_post_adder dut (
        .clk       (clk),
        .rst       (rst),
        .cep       (cep),
        .cecarryin (cecarryin),
        .ceopmode  (ceopmode),
        .opmode    (opmode),
        .m_in      (m_in),
        .dab_in    (dab_in),
        .c_in      (c_in),
        .pcin      (pcin),
        .carry_in  (carry_in),
        .p         (p),
        .pcout     (pcout),
        .carryout  (carryout),
        .carryoutf (carryoutf)
    );

    dsp_post_adder #(
        .PREG        (1'b0),
        .CARRYOUTREG (1'b0),
        .CARRYINREG  (1'b0),
        .OPMODEREG   (1'b0)
    ) dut_byp (
        .clk       (clk),
        .rst       (rst),
        .cep       (cep),
        .cecarryin (cecarryin),
        .ceopmode  (ceopmode),
        .opmode    (opmode),
        .m_in      (m_in),
        .dab_in    (dab_in),
        .c_in      (c_in),
        .pcin      (pcin),
        .carry_in  (carry_in),
        .p         (p_b),
        .pcout     (pcout_b),
        .carryout  (carryout_b),
        .carryoutf (carryoutf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: 49-bit result {carry/borrow, P} from the operand-select and
    // add/subtract rules, with fb standing for the current accumulator value.
    function automatic logic [48:0] ref_sum(input logic [7:0] op, input logic [35:0] m,
                                            input logic [47:0] dab, input logic [47:0] c,
                                            input logic [47:0] pc, input logic [47:0] fb,
                                            input logic cin);
        logic [48:0] x;
        logic [48:0] z;
        case (op[1:0])
            2'd0:    x = 49'd0;
            2'd1:    x = {13'd0, m};
            2'd2:    x = {1'b0, fb};
            default: x = {1'b0, dab};
        endcase
        case (op[3:2])
            2'd0:    z = 49'd0;
            2'd1:    z = {1'b0, pc};
            2'd2:    z = {1'b0, fb};
            default: z = {1'b0, c};
        endcase
        if (op[7]) return z - (x + 49'(cin));
        return z + x + 49'(cin);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        opmode = 8'h0D; c_in = 48'd5; m_in = 36'd3; dab_in = '0; pcin = '0;
        carry_in = 1'b0; cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (p !== 48'd0) begin
            errors++; $display("[TB] FAIL reset_p got %h expected %h", p, 48'd0);
        end
        checks++;
        if (carryout !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_carryout got %b expected 0", carryout);
        end
        checks++;
        if (pcout !== 48'd0 || carryoutf !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_pcout got %h/%b expected 0/0", pcout, carryoutf);
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (p !== 48'd8) begin
            errors++; $display("[TB] FAIL reset_first_edge got %0d expected 8", p);
        end
    endtask

    task automatic test_subtract;
        do_reset();
        opmode = 8'h8D; c_in = 48'd2; m_in = 36'd5; carry_in = 1'b0;
        cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
        tick();
        checks++;
        if (p !== 48'hFFFF_FFFF_FFFD) begin
            errors++; $display("[TB] FAIL subtract_p got %h expected %h", p, 48'hFFFF_FFFF_FFFD);
        end
        checks++;
        if (carryout !== 1'b1 || carryoutf !== 1'b1) begin
            errors++; $display("[TB] FAIL subtract_borrow got %b/%b expected 1/1", carryout, carryoutf);
        end
    endtask

    task automatic test_accumulate;
        do_reset();
        opmode = 8'h09; m_in = 36'd7; carry_in = 1'b0;
        cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (p !== 48'(7 * i)) begin
                errors++; $display("[TB] FAIL accumulate_step%0d got %0d expected %0d", i, p, 7 * i);
            end
        end
        cep = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (p !== 48'd28) begin
                errors++; $display("[TB] FAIL accumulate_hold got %0d expected 28", p);
            end
        end
        cep = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
        checks++;
        if (p !== 48'd7) begin
            errors++; $display("[TB] FAIL accumulate_after_reset got %0d expected 7", p);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        opmode = 8'h0F; dab_in = 48'hFFFF_FFFF_FFFF; c_in = 48'd1; carry_in = 1'b1;
        cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
        tick();
        checks++;
        if (p !== 48'd1 || pcout !== 48'd1) begin
            errors++; $display("[TB] FAIL wrap_p got %h/%h expected 1/1", p, pcout);
        end
        checks++;
        if (carryout !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap_carryout got %b expected 1", carryout);
        end
    endtask

    task automatic test_bypass;
        opmode = 8'h07; pcin = 48'd10; dab_in = 48'd20; carry_in = 1'b0;
        #1;
        checks++;
        if (p_b !== 48'd30) begin
            errors++; $display("[TB] FAIL bypass_p got %0d expected 30", p_b);
        end
        checks++;
        if (pcout_b !== 48'd30 || carryout_b !== 1'b0 || carryoutf_b !== 1'b0) begin
            errors++; $display("[TB] FAIL bypass_pcout got %0d/%b/%b expected 30/0/0",
                               pcout_b, carryout_b, carryoutf_b);
        end
    endtask

    task automatic test_ce_gating;
        do_reset();
        opmode = 8'h0D; c_in = 48'd5; m_in = 36'd3; carry_in = 1'b0;
        cep = 1'b1; ceopmode = 1'b1; cecarryin = 1'b1;
        tick();
        ceopmode = 1'b0; opmode = 8'h8D;
        tick();
        checks++;
        if (p !== 48'd8 || carryout !== 1'b0) begin
            errors++; $display("[TB] FAIL ce_opmode_hold got %0d/%b expected 8/0", p, carryout);
        end
        c_in = 48'd10;
        cecarryin = 1'b0; carry_in = 1'b1;
        tick();
        checks++;
        if (p !== 48'd13) begin
            errors++; $display("[TB] FAIL ce_carryin_hold got %0d expected 13", p);
        end
        ceopmode = 1'b1;
        tick();
        checks++;
        if (p !== 48'd7) begin
            errors++; $display("[TB] FAIL ce_opmode_reload got %0d expected 7", p);
        end
    endtask

    task automatic test_random;
        logic [47:0] mp;
        logic        mco;
        logic [7:0]  hop;
        logic        hcin;
        logic [47:0] bp;
        logic [7:0]  op_e;
        logic        cin_e;
        logic [48:0] r;
        do_reset();
        mp = '0; mco = 1'b0; hop = '0; hcin = 1'b0; bp = '0;
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            opmode    = 8'($urandom);
            m_in      = 36'({$urandom, $urandom});
            dab_in    = 48'({$urandom, $urandom});
            c_in      = 48'({$urandom, $urandom});
            pcin      = 48'({$urandom, $urandom});
            carry_in  = 1'($urandom_range(0, 1));
            cep       = ($urandom_range(0, 3) != 0);
            ceopmode  = ($urandom_range(0, 3) != 0);
            cecarryin = ($urandom_range(0, 3) != 0);
            if (rst) bp = '0;
            #1;
            if (!rst) begin
                r = ref_sum(opmode, m_in, dab_in, c_in, pcin, bp, carry_in);
                checks++;
                if (p_b !== r[47:0] || carryout_b !== r[48]) begin
                    errors++; $display("[TB] FAIL random_bypass it%0d got %h/%b expected %h/%b",
                                       i, p_b, carryout_b, r[47:0], r[48]);
                end
            end
            if (rst) begin
                mp = '0; mco = 1'b0; hop = '0; hcin = 1'b0; bp = '0;
            end else begin
                op_e  = ceopmode ? opmode : hop;
                cin_e = cecarryin ? carry_in : hcin;
                if (cep) begin
                    r   = ref_sum(op_e, m_in, dab_in, c_in, pcin, mp, cin_e);
                    mp  = r[47:0];
                    mco = r[48];
                    r   = ref_sum(opmode, m_in, dab_in, c_in, pcin, bp, carry_in);
                    bp  = r[47:0];
                end
                if (ceopmode) hop = opmode;
                if (cecarryin) hcin = carry_in;
            end
            tick();
            checks++;
            if (p !== mp || pcout !== mp || carryout !== mco || carryoutf !== mco) begin
                errors++; $display("[TB] FAIL random_main it%0d got %h/%h/%b/%b expected %h/%b",
                                   i, p, pcout, carryout, carryoutf, mp, mco);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        cep = 1'b0; cecarryin = 1'b0; ceopmode = 1'b0;
        opmode = '0; m_in = '0; dab_in = '0; c_in = '0; pcin = '0; carry_in = 1'b0;
        tick();
        rst = 1'b0;
        test_reset();
        test_subtract();
        test_accumulate();
        test_wrap();
        test_bypass();
        test_ce_gating();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
